// File: rtl/ram_fifo_pkg.sv
// Shared constants and encodings for the 4x72 RAM-backed FIFO controller.
package ram_fifo_pkg;

  localparam int DATA_W = 72;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_e;

  localparam logic RAM_EN_ON    = 1'b0;
  localparam logic RAM_EN_OFF   = 1'b1;
  localparam logic RAM_WR_WRITE = 1'b0;
  localparam logic RAM_WR_READ  = 1'b1;

endpackage

// File: rtl/ram_fifo_ptr.sv
// Write/read pointers and occupancy counter for the RAM slots of the FIFO controller.
module ram_fifo_ptr
  import ram_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [2:0]        ram_cnt,
  output logic              full,
  output logic              empty
);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0]        ram_cnt_q, ram_cnt_d;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ram_cnt_d = ram_cnt_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
    case ({wr_en, rd_en})
      2'b10:   ram_cnt_d = ram_cnt_q + 3'd1;
      2'b01:   ram_cnt_d = ram_cnt_q - 3'd1;
      default: ram_cnt_d = ram_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= 3'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
    end
  end

  assign wr_ptr  = wr_ptr_q;
  assign rd_ptr  = rd_ptr_q;
  assign ram_cnt = ram_cnt_q;
  assign full    = (ram_cnt_q == 3'(DEPTH));
  assign empty   = (ram_cnt_q == 3'd0);

endmodule

// File: rtl/ram_fifo_ctrl_4x72.sv
// FIFO controller around a 4x72 single-port RAM with a registered output stage.
// Optional FIFO_BYPASS_EN: words arriving at an empty FIFO skip the RAM.
module ram_fifo_ctrl_4x72
  import ram_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [2:0]        level,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_en,
  output logic              ram_wr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_e            state_q, state_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [2:0]        level_q, level_d;

  logic              read_issue_s, accept_s, pop_s, bypass_s, write_s;
  logic [ADDR_W-1:0] wr_ptr_s, rd_ptr_s;
  logic [2:0]        ram_cnt_s;
  logic              full_s, empty_s;

  ram_fifo_ptr u_ptr (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (write_s),
    .rd_en   (read_issue_s),
    .wr_ptr  (wr_ptr_s),
    .rd_ptr  (rd_ptr_s),
    .ram_cnt (ram_cnt_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  // Single RAM port: a read, once eligible, always takes the port over a write.
  always_comb begin
    read_issue_s = !rst && (state_q == IDLE) && !empty_s && (!m_valid_q || m_ready);
    s_ready      = !rst && !full_s && !read_issue_s;
    accept_s     = s_valid && s_ready;
    pop_s        = m_valid_q && m_ready;
`ifdef FIFO_BYPASS_EN
    bypass_s     = accept_s && (state_q == IDLE) && empty_s && (!m_valid_q || m_ready);
`else
    bypass_s     = 1'b0;
`endif
    write_s      = accept_s && !bypass_s;
  end

  always_comb begin
    ram_en      = RAM_EN_OFF;
    ram_wr      = RAM_WR_READ;
    ram_address = '0;
    ram_wdata   = '0;
    if (read_issue_s) begin
      ram_en      = RAM_EN_ON;
      ram_wr      = RAM_WR_READ;
      ram_address = rd_ptr_s;
    end else if (write_s) begin
      ram_en      = RAM_EN_ON;
      ram_wr      = RAM_WR_WRITE;
      ram_address = wr_ptr_s;
      ram_wdata   = s_data;
    end else begin
      ram_en      = RAM_EN_OFF;
    end
  end

  // Read data is only valid in RD_WAIT, the cycle after the access.
  always_comb begin
    state_d   = state_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    if (pop_s) begin
      m_valid_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (read_issue_s) begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        state_d   = IDLE;
        m_valid_d = 1'b1;
        m_data_d  = ram_rdata;
      end
      default: state_d = IDLE;
    endcase
    if (bypass_s) begin
      m_valid_d = 1'b1;
      m_data_d  = s_data;
    end
    case ({accept_s, pop_s})
      2'b10:   level_d = level_q + 3'd1;
      2'b01:   level_d = level_q - 3'd1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      level_q   <= 3'd0;
    end else begin
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      level_q   <= level_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign level   = level_q;

endmodule

// File: tb/tb_ram_fifo_ctrl_4x72.sv
// Directed bench for ram_fifo_ctrl_4x72 with a behavioural 4x72 RAM behind it.
module tb_ram_fifo_ctrl_4x72;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [71:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [71:0] m_data;
  logic [2:0]  level;
  logic [1:0]  ram_address;
  logic        ram_en;
  logic        ram_wr;
  logic [71:0] ram_wdata;
  logic [71:0] ram_rdata;

  logic [71:0] mem [4];

  int n_checks = 0;
  int n_errors = 0;

  ram_fifo_ctrl_4x72 dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .level       (level),
    .ram_address (ram_address),
    .ram_en      (ram_en),
    .ram_wr      (ram_wr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read single-port RAM, as dff_ram_4x72 behaves.
  always_ff @(posedge clk) begin
    if (!ram_en) begin
      if (!ram_wr) mem[ram_address] <= ram_wdata;
      else         ram_rdata <= mem[ram_address];
    end
  end

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [71:0] d);
    s_valid = 1'b1;
    s_data  = d;
    #1;
    for (int i = 0; i < 20 && !s_ready; i++) tick();
    check("push_ready", s_ready, 1);
    tick();
    s_valid = 1'b0;
    #1;
  endtask

  task automatic drain(input int n, input logic [71:0] base);
    int k;
    k = 0;
    m_ready = 1'b1;
    #1;
    for (int c = 0; c < 60 && k < n; c++) begin
      if (m_valid) begin
        check("drain_data", m_data, base + 72'(k));
        k++;
      end
      tick();
    end
    m_ready = 1'b0;
    #1;
    check("drain_count", 72'(k), 72'(n));
  endtask

  initial begin
    int sent, recv;
    logic acc;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    ram_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    // 1. reset
    check("rst_ram_en", ram_en, 1);
    check("rst_ram_wr", ram_wr, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_level", level, 0);
    check("rst_s_ready", s_ready, 0);
    rst = 1'b0;
    #1;

    // 2. single word latency through RAM
`ifndef FIFO_BYPASS_EN
    s_valid = 1'b1; s_data = {9{8'hAA}};
    #1;
    check("t2_s_ready", s_ready, 1);
    check("t2_wr_en", ram_en, 0);
    check("t2_wr_sel", ram_wr, 0);
    check("t2_wr_addr", ram_address, 0);
    check("t2_wr_data", ram_wdata, {9{8'hAA}});
    tick();
    s_valid = 1'b0;
    #1;
    check("t2_rd_en", ram_en, 0);
    check("t2_rd_sel", ram_wr, 1);
    check("t2_rd_addr", ram_address, 0);
    tick();
    check("t2_wait_mvalid", m_valid, 0);
    check("t2_wait_ram_en", ram_en, 1);
    tick();
    check("t2_m_valid", m_valid, 1);
    check("t2_m_data", m_data, {9{8'hAA}});
    check("t2_level", level, 1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    #1;
    check("t2_pop_valid", m_valid, 0);
    check("t2_pop_level", level, 0);
`endif

    // 3. fill to 5, full, then drain in order across pointer wrap
    for (int i = 1; i <= 5; i++) push(72'(i));
    check("t3_level5", level, 5);
    s_valid = 1'b1; s_data = 72'd6;
    #1;
    check("t3_full_ready", s_ready, 0);
    s_valid = 1'b0;
    drain(5, 72'd1);
    check("t3_level0", level, 0);

    // 4. streaming 20 words with downstream always ready
    sent = 0; recv = 0;
    m_ready = 1'b1;
    for (int c = 0; c < 300 && recv < 20; c++) begin
      s_valid = (sent < 20);
      s_data  = 72'd100 + 72'(sent);
      #1;
      acc = s_valid && s_ready;
      if (m_valid) begin
        check("t4_order", m_data, 72'd100 + 72'(recv));
        recv++;
      end
      @(posedge clk);
      if (acc) sent++;
      #1;
    end
    s_valid = 1'b0; m_ready = 1'b0;
    #1;
    check("t4_recv", 72'(recv), 72'd20);
    check("t4_level", level, 0);

    // 5. reset while a read is in flight
    for (int i = 0; i < 4; i++) push(72'h40 + 72'(i));
    check("t5_level4", level, 4);
    m_ready = 1'b1;
    #1;
    check("t5_rd_issue", {ram_en, ram_wr}, 2'b01);
    tick();
    m_ready = 1'b0;
    #1;
    check("t5_level3", level, 3);
    rst = 1'b1;
    tick();
    check("t5_rst_mvalid", m_valid, 0);
    check("t5_rst_level", level, 0);
    check("t5_rst_ram_en", ram_en, 1);
    rst = 1'b0;
    #1;
    push(72'h1);
    for (int c = 0; c < 10 && !m_valid; c++) tick();
    check("t5_after_valid", m_valid, 1);
    check("t5_after_data", m_data, 72'h1);
    check("t5_after_level", level, 1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    #1;
    check("t5_after_pop", level, 0);

`ifdef FIFO_BYPASS_EN
    // 6. bypass into the output register
    s_valid = 1'b1; s_data = 72'h5;
    #1;
    check("t6_ram_en", ram_en, 1);
    tick();
    s_valid = 1'b0;
    #1;
    check("t6_m_valid", m_valid, 1);
    check("t6_m_data", m_data, 72'h5);
    check("t6_ram_idle", ram_en, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
